cycle_step_sequencer: RTL and testbench

Drives the control unit's instruction timing: fetches an opcode byte, then issues a one-hot cycle-step vector to the microcode blocks. Each microcode block gates its control outputs with its own active select and the step bits. The sequencer consumes the ORed Reset_Cycle from all microcode blocks to end an instruction and return to fetch. It handles the 0xCB prefix and holds steps on stall.

---
 rtl/cycle_step_sequencer_pkg.sv | 15 +
 rtl/cycle_step_ring.sv | 29 ++
 rtl/cycle_step_sequencer.sv | 118 +++++++++++
 tb/tb_cycle_step_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_step_sequencer_pkg.sv
// Shared types and constants for the instruction cycle-step sequencer and its
// microcode consumers.
package cycle_step_sequencer_pkg;

  localparam int unsigned DEFAULT_NUM_STEPS = 16;
  localparam int unsigned OPCODE_W          = 8;
  localparam logic [OPCODE_W-1:0] CB_PREFIX_BYTE = 8'hCB;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cycle_step_ring.sv
// One-hot step shift register: clear beats load beats hold beats advance.
module cycle_step_ring #(
  parameter int unsigned NUM_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 hold,
  input  logic                 advance,
  output logic [NUM_STEPS-1:0] step,
  output logic                 last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (clear) begin
      step <= '0;
    end else if (load) begin
      step <= NUM_STEPS'(1);
    end else if (advance && !hold) begin
      step <= {step[NUM_STEPS-2:0], 1'b0};
    end
  end

  assign last = step[NUM_STEPS-1];

endmodule

// File: rtl/cycle_step_sequencer.sv
// Fetches an opcode (with optional 0xCB prefix) and walks a one-hot step vector
// through EXEC until a microcode block asserts Reset_Cycle or the steps run out.
module cycle_step_sequencer
  import cycle_step_sequencer_pkg::*;
#(
  parameter int unsigned          NUM_STEPS = DEFAULT_NUM_STEPS,
  parameter logic [OPCODE_W-1:0]  CB_PREFIX = CB_PREFIX_BYTE
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset_n,
  output logic                 o_Fetch_Req,
  input  logic                 i_Fetch_Ack,
  input  logic [OPCODE_W-1:0]  i_Fetch_Data,
  input  logic                 i_Stall,
  input  logic                 i_Reset_Cycle,
  output logic [OPCODE_W-1:0]  o_Opcode,
  output logic                 o_CB_Prefix,
  output logic                 o_Exec,
  output logic [NUM_STEPS-1:0] o_Cycle_Step,
  output logic                 o_Overrun
);

  seq_state_e          state, state_nxt;
  logic                cb_flag, cb_flag_nxt;
  logic [OPCODE_W-1:0] opcode, opcode_nxt;
  logic                cb_prefix, cb_prefix_nxt;
  logic                overrun, overrun_nxt;
  logic                ring_load, ring_clear, ring_hold, ring_advance;
  logic                ring_last;

  // State and latched instruction context
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      cb_flag   <= 1'b0;
      opcode    <= '0;
      cb_prefix <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cb_flag   <= cb_flag_nxt;
      opcode    <= opcode_nxt;
      cb_prefix <= cb_prefix_nxt;
      overrun   <= overrun_nxt;
    end
  end

  // Next-state and step-ring control
  always_comb begin
    state_nxt     = state;
    cb_flag_nxt   = cb_flag;
    opcode_nxt    = opcode;
    cb_prefix_nxt = cb_prefix;
    overrun_nxt   = 1'b0;
    ring_load     = 1'b0;
    ring_clear    = 1'b0;
    ring_hold     = 1'b0;
    ring_advance  = 1'b0;

    unique case (state)
      ST_IDLE: state_nxt = ST_FETCH;

      ST_FETCH: begin
        if (i_Fetch_Ack) begin
          // A second 0xCB after a prefix is an ordinary opcode byte.
          if ((i_Fetch_Data == CB_PREFIX) && !cb_flag) begin
            cb_flag_nxt = 1'b1;
          end else begin
            opcode_nxt    = i_Fetch_Data;
            cb_prefix_nxt = cb_flag;
            cb_flag_nxt   = 1'b0;
            ring_load     = 1'b1;
            state_nxt     = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (i_Reset_Cycle) begin
          ring_clear    = 1'b1;
          cb_prefix_nxt = 1'b0;
          state_nxt     = ST_FETCH;
        end else if (i_Stall) begin
          ring_hold = 1'b1;
        end else if (ring_last) begin
          overrun_nxt   = 1'b1;
          ring_clear    = 1'b1;
          cb_prefix_nxt = 1'b0;
          state_nxt     = ST_FETCH;
        end else begin
          ring_advance = 1'b1;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  cycle_step_ring #(
    .NUM_STEPS (NUM_STEPS)
  ) u_ring (
    .clk     (i_Clk),
    .rst_n   (i_Reset_n),
    .load    (ring_load),
    .clear   (ring_clear),
    .hold    (ring_hold),
    .advance (ring_advance),
    .step    (o_Cycle_Step),
    .last    (ring_last)
  );

  assign o_Fetch_Req = (state == ST_FETCH);
  assign o_Exec      = (state == ST_EXEC);
  assign o_Opcode    = opcode;
  assign o_CB_Prefix = cb_prefix;
  assign o_Overrun   = overrun;

endmodule

// File: tb/tb_cycle_step_sequencer.sv
// Directed bench for cycle_step_sequencer: reset, NOP timing, stall, CB prefix,
// step overrun and asynchronous reset mid-instruction.
module tb_cycle_step_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        stall;
  logic        reset_cycle;
  logic [7:0]  opcode;
  logic        cb_prefix;
  logic        exec;
  logic [15:0] cycle_step;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  cycle_step_sequencer #(
    .NUM_STEPS (16),
    .CB_PREFIX (8'hCB)
  ) dut (
    .i_Clk         (clk),
    .i_Reset_n     (rst_n),
    .o_Fetch_Req   (fetch_req),
    .i_Fetch_Ack   (fetch_ack),
    .i_Fetch_Data  (fetch_data),
    .i_Stall       (stall),
    .i_Reset_Cycle (reset_cycle),
    .o_Opcode      (opcode),
    .o_CB_Prefix   (cb_prefix),
    .o_Exec        (exec),
    .o_Cycle_Step  (cycle_step),
    .o_Overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled at the falling edge, then inputs for the next rising edge are driven.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic f, input logic e,
                         input logic [15:0] s, input logic [7:0] op,
                         input logic cb, input logic ov);
    chk({tag, ".fetch"},   32'(fetch_req),  32'(f));
    chk({tag, ".exec"},    32'(exec),       32'(e));
    chk({tag, ".step"},    32'(cycle_step), 32'(s));
    chk({tag, ".opcode"},  32'(opcode),     32'(op));
    chk({tag, ".cb"},      32'(cb_prefix),  32'(cb));
    chk({tag, ".overrun"}, 32'(overrun),    32'(ov));
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_ack   = 1'b0;
    fetch_data  = 8'h00;
    stall       = 1'b0;
    reset_cycle = 1'b0;

    // 1. Reset, then fetch one cycle after release
    #12;
    chk_all("rst", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    next_cycle();
    chk_all("rst_hold", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_idle", 32'(fetch_req), 32'd0);
    next_cycle();
    chk_all("rel_fetch", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    // 2. Zero-wait fetch of 0x00, Reset_Cycle at bit3
    reset_cycle = 1'b1;  // ignored in FETCH
    next_cycle();
    chk("rc_in_fetch", 32'(fetch_req), 32'd1);
    reset_cycle = 1'b0;
    fetch_ack   = 1'b1;
    fetch_data  = 8'h00;
    next_cycle();
    fetch_ack = 1'b0;
    chk_all("nop_s0", 1'b0, 1'b1, 16'h0001, 8'h00, 1'b0, 1'b0);
    next_cycle();
    chk("nop_s1", 32'(cycle_step), 32'h0002);
    next_cycle();
    chk("nop_s2", 32'(cycle_step), 32'h0004);
    next_cycle();
    chk("nop_s3", 32'(cycle_step), 32'h0008);
    reset_cycle = 1'b1;
    next_cycle();
    reset_cycle = 1'b0;
    chk_all("nop_end", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    // Back-to-back NOPs: fetch recurs every 5 cycles
    for (int n = 0; n < 2; n++) begin
      fetch_ack  = 1'b1;
      fetch_data = 8'h00;
      next_cycle();
      fetch_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b2b%0d_s%0d", n, k), 32'(cycle_step), 32'(16'h0001 << k));
        if (k == 3) reset_cycle = 1'b1;
        next_cycle();
      end
      reset_cycle = 1'b0;
      chk($sformatf("b2b%0d_fetch", n), 32'(fetch_req), 32'd1);
    end

    // 3. Stall at 0010 for three cycles, then Reset_Cycle together with Stall
    fetch_ack  = 1'b1;
    fetch_data = 8'h00;
    next_cycle();
    fetch_ack = 1'b0;
    chk("stl_s0", 32'(cycle_step), 32'h0001);
    next_cycle();
    chk("stl_s1", 32'(cycle_step), 32'h0002);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk($sformatf("stl_hold%0d", k), 32'(cycle_step), 32'h0002);
    end
    stall = 1'b0;
    next_cycle();
    chk("stl_s2", 32'(cycle_step), 32'h0004);
    stall       = 1'b1;
    reset_cycle = 1'b1;
    next_cycle();
    stall       = 1'b0;
    reset_cycle = 1'b0;
    chk_all("stl_rc", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);

    // 4. CB prefix then 0x37
    fetch_ack  = 1'b1;
    fetch_data = 8'hCB;
    next_cycle();
    chk_all("cb_mid", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    fetch_data = 8'h37;
    next_cycle();
    fetch_ack = 1'b0;
    chk_all("cb_37", 1'b0, 1'b1, 16'h0001, 8'h37, 1'b1, 1'b0);
    reset_cycle = 1'b1;
    next_cycle();
    reset_cycle = 1'b0;
    chk_all("cb_clr", 1'b1, 1'b0, 16'h0000, 8'h37, 1'b0, 1'b0);

    // CB CB: the second CB is the opcode
    fetch_ack  = 1'b1;
    fetch_data = 8'hCB;
    next_cycle();
    chk("cbcb_mid", 32'(fetch_req), 32'd1);
    next_cycle();
    fetch_ack = 1'b0;
    chk_all("cbcb_op", 1'b0, 1'b1, 16'h0001, 8'hCB, 1'b1, 1'b0);
    reset_cycle = 1'b1;
    next_cycle();
    reset_cycle = 1'b0;
    chk("cbcb_clr", 32'(cb_prefix), 32'd0);

    // Plain opcode after a CB instruction must not inherit the prefix
    fetch_ack  = 1'b1;
    fetch_data = 8'h12;
    next_cycle();
    fetch_ack = 1'b0;
    chk_all("plain", 1'b0, 1'b1, 16'h0001, 8'h12, 1'b0, 1'b0);
    reset_cycle = 1'b1;
    next_cycle();
    reset_cycle = 1'b0;

    // 5. Overrun after 16 steps
    fetch_ack  = 1'b1;
    fetch_data = 8'h00;
    next_cycle();
    fetch_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("ovr_s%0d", k), 32'(cycle_step), 32'(16'h0001 << k));
      chk($sformatf("ovr_flag%0d", k), 32'(overrun), 32'd0);
      next_cycle();
    end
    chk_all("ovr_pulse", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1);
    next_cycle();
    chk("ovr_drop", 32'(overrun), 32'd0);
    chk("ovr_fetch", 32'(fetch_req), 32'd1);

    // 6. Async reset at step 0100
    fetch_ack  = 1'b1;
    fetch_data = 8'h5A;
    next_cycle();
    fetch_ack = 1'b0;
    next_cycle();
    next_cycle();
    chk("ar_pre_step", 32'(cycle_step), 32'h0004);
    chk("ar_pre_op", 32'(opcode), 32'h5A);
    rst_n = 1'b0;
    #1;
    chk_all("ar_now", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("ar_rel_idle", 32'(fetch_req), 32'd0);
    next_cycle();
    chk_all("ar_fetch", 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0);
    next_cycle();
    chk("ar_no_ovr", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
